// File: rtl/filter_phase_engine.sv
// Filter-phase responder: walks the image one 32-bit word at a time (read -> filter -> write-back).
// Optional memory watchdog with sticky phase_error is enabled by defining MEM_TIMEOUT_EN.
module filter_phase_engine #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int NUM_WORDS  = IMG_WIDTH * IMG_HEIGHT / 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en_filter_phase,
    input  logic [1:0]  system_filter,
    input  logic [31:0] input_address,
    input  logic [31:0] output_address,
    output logic        filter_phase_done,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        pix_out_valid,
    output logic [31:0] pix_out_data,
    output logic [1:0]  pix_out_filter,
    input  logic        pix_out_ready,
    input  logic        pix_in_valid,
    input  logic [31:0] pix_in_data
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        phase_error
`endif
);

    localparam int          IDX_W    = 17;
    localparam logic [16:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_RESULT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        rd_addr_q, rd_addr_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        result_q, result_d;
    logic [1:0]         filter_q, filter_d;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]         wdog_q, wdog_d;
    logic               err_q, err_d;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            word_q    <= '0;
            result_q  <= '0;
            filter_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            wdog_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            word_q    <= word_d;
            result_q  <= result_d;
            filter_q  <= filter_d;
`ifdef MEM_TIMEOUT_EN
            wdog_q    <= wdog_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        word_d    = word_q;
        result_d  = result_q;
        filter_d  = filter_q;
`ifdef MEM_TIMEOUT_EN
        wdog_d    = '0;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en_filter_phase) begin
                    filter_d  = system_filter;
                    rd_addr_d = input_address;
                    wr_addr_d = output_address;
                    idx_d     = '0;
`ifdef MEM_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    word_d  = mem_rdata;
                    state_d = S_SEND;
                end
`ifdef MEM_TIMEOUT_EN
                // 255th consecutive unacknowledged cycle abandons the phase
                else if (wdog_q == 8'd254) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_SEND: begin
                if (pix_out_ready) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (pix_in_valid) begin
                    result_d = pix_in_data;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        // Byte addresses advance by one word and wrap modulo 2^32
                        idx_d     = idx_q + 17'd1;
                        rd_addr_d = rd_addr_q + 32'd4;
                        wr_addr_d = wr_addr_q + 32'd4;
                        state_d   = S_READ;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is decoded from registered state only
    always_comb begin
        mem_addr = '0;
        if (state_q == S_READ) begin
            mem_addr = rd_addr_q;
        end else if (state_q == S_WRITE) begin
            mem_addr = wr_addr_q;
        end
    end

    assign mem_read          = (state_q == S_READ);
    assign mem_write         = (state_q == S_WRITE);
    assign mem_wdata         = result_q;
    assign pix_out_valid     = (state_q == S_SEND);
    assign pix_out_data      = word_q;
    assign pix_out_filter    = filter_q;
    assign filter_phase_done = (state_q == S_DONE);
`ifdef MEM_TIMEOUT_EN
    assign phase_error       = err_q;
`endif

endmodule

// File: tb/tb_filter_phase_engine.sv
// Randomized bench for filter_phase_engine: reactive memory/datapath responders plus a
// reference model of each phase's expected read/write address and data sequence.
module tb_filter_phase_engine;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en_filter_phase = 1'b0;
    logic [1:0]  system_filter = '0;
    logic [31:0] input_address = '0;
    logic [31:0] output_address = '0;
    logic        filter_phase_done;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        pix_out_valid;
    logic [31:0] pix_out_data;
    logic [1:0]  pix_out_filter;
    logic        pix_out_ready = 1'b0;
    logic        pix_in_valid = 1'b0;
    logic [31:0] pix_in_data = '0;
`ifdef MEM_TIMEOUT_EN
    logic        phase_error;
`endif

    filter_phase_engine #(.IMG_WIDTH(8), .IMG_HEIGHT(2)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .en_filter_phase(en_filter_phase),
        .system_filter(system_filter),
        .input_address(input_address),
        .output_address(output_address),
        .filter_phase_done(filter_phase_done),
        .mem_addr(mem_addr),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .pix_out_valid(pix_out_valid),
        .pix_out_data(pix_out_data),
        .pix_out_filter(pix_out_filter),
        .pix_out_ready(pix_out_ready),
        .pix_in_valid(pix_in_valid),
        .pix_in_data(pix_in_data)
`ifdef MEM_TIMEOUT_EN
        ,
        .phase_error(phase_error)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder controls and logs
    int          lat_max = 0;
    int          rdy_pct = 100;
    bit          ready_block = 0;
    bit          result_block = 0;
    bit          read_block = 0;
    bit          spurious_en = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          mem_wait = 0;
    bit          res_pending = 0;
    logic [31:0] res_data = '0;
    int          res_wait = 0;
    int          done_cnt = 0;
    int unsigned done_cyc = 0;

    // Source image content: a fixed hash of the byte address
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("cmp %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Memory and filter-datapath models, reacting between clock edges
    initial begin
        forever begin
            @(negedge clk);
            mem_ack      = 1'b0;
            pix_in_valid = 1'b0;
            mem_rdata    = $urandom;
            pix_in_data  = $urandom;
            if (!n_rst) begin
                mem_wait      = 0;
                res_pending   = 0;
                pix_out_ready = 1'b0;
            end else begin
                if (mem_read || mem_write) begin
                    if (mem_read && read_block) begin
                        mem_ack = 1'b0;
                    end else if (mem_wait > 0) begin
                        mem_wait--;
                    end else begin
                        mem_ack = 1'b1;
                        if (mem_read) begin
                            mem_rdata = mem_val(mem_addr);
                            rd_log.push_back(mem_addr);
                        end else begin
                            wr_addr_log.push_back(mem_addr);
                            wr_data_log.push_back(mem_wdata);
                        end
                        mem_wait = $urandom_range(lat_max, 0);
                    end
                end else if (spurious_en && $urandom_range(3, 0) == 0) begin
                    mem_ack = 1'b1;
                end
                if (res_pending) begin
                    if (!result_block) begin
                        if (res_wait > 0) begin
                            res_wait--;
                        end else begin
                            pix_in_valid = 1'b1;
                            pix_in_data  = res_data;
                            res_pending  = 0;
                        end
                    end
                end else if (spurious_en && $urandom_range(3, 0) == 0) begin
                    pix_in_valid = 1'b1;
                end
                pix_out_ready = !ready_block && ($urandom_range(99, 0) < rdy_pct);
                if (pix_out_valid && pix_out_ready) begin
                    res_pending = 1;
                    res_data    = pix_out_data + 32'd1;
                    res_wait    = $urandom_range(lat_max, 0);
                end
                if (filter_phase_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic start_phase(input logic [31:0] ib, input logic [31:0] ob, input logic [1:0] f,
                               output int unsigned c);
        @(negedge clk);
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        en_filter_phase = 1'b1;
        system_filter   = f;
        input_address   = ib;
        output_address  = ob;
        c = cyc;
        @(negedge clk);
        en_filter_phase = 1'b0;
        system_filter   = 2'($urandom);
        input_address   = $urandom;
        output_address  = $urandom;
    endtask

    task automatic wait_done(input int base_cnt, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > base_cnt) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Reference: word k is read from ib+4k and written, plus one, to ob+4k
    task automatic check_phase(input logic [31:0] ib, input logic [31:0] ob);
        chk("rd_count", 32'(rd_log.size()), 32'(NW));
        chk("wr_count", 32'(wr_addr_log.size()), 32'(NW));
        for (int k = 0; k < NW; k++) begin
            if (k < rd_log.size()) chk("rd_addr", rd_log[k], ib + 32'(4 * k));
            if (k < wr_addr_log.size()) begin
                chk("wr_addr", wr_addr_log[k], ob + 32'(4 * k));
                chk("wr_data", wr_data_log[k], mem_val(ib + 32'(4 * k)) + 32'd1);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"}, 32'(filter_phase_done), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_rd"}, 32'(mem_read), 32'd0);
        chk({tag, "_wr"}, 32'(mem_write), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_pvalid"}, 32'(pix_out_valid), 32'd0);
        chk({tag, "_pdata"}, pix_out_data, 32'd0);
        chk({tag, "_pfilt"}, 32'(pix_out_filter), 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk({tag, "_perr"}, 32'(phase_error), 32'd0);
`endif
    endtask

    initial begin
        int unsigned sc;
        int          d0;
        bit          seen;
        logic [31:0] ib, ob;
        logic [1:0]  f;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        n_rst = 1'b1;

        // Back-to-back phases at full speed: exact 4*N+1 latency
        lat_max = 0;
        rdy_pct = 100;
        d0 = done_cnt;
        start_phase(32'h1000, 32'h2000, 2'd2, sc);
        wait_done(d0, 200);
        check_phase(32'h1000, 32'h2000);
        chk("latency", done_cyc - sc, 32'(4 * NW + 1));
        chk("filter_latch", 32'(pix_out_filter), 32'd2);
        d0 = done_cnt;
        start_phase(32'hFFFFFFF8, 32'h8000, 2'd1, sc);
        wait_done(d0, 200);
        check_phase(32'hFFFFFFF8, 32'h8000);
        chk("latency_b2b", done_cyc - sc, 32'(4 * NW + 1));
        repeat (4) @(negedge clk);
        chk("single_pulse", 32'(done_cnt - d0), 32'd1);

        // Datapath backpressure: offered word must hold steady
        ready_block = 1;
        d0 = done_cnt;
        start_phase(32'h4000, 32'h5000, 2'd3, sc);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pix_out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("stall_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(pix_out_valid), 32'd1);
            chk("stall_data", pix_out_data, mem_val(32'h4000));
            chk("stall_noread", 32'(mem_read), 32'd0);
        end
        ready_block = 0;
        wait_done(d0, 200);
        check_phase(32'h4000, 32'h5000);

        // Start pulse while waiting for the filter result must be ignored
        result_block = 1;
        d0 = done_cnt;
        start_phase(32'h1000, 32'h2000, 2'd1, sc);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (res_pending) begin
                seen = 1;
                break;
            end
        end
        chk("result_wait_seen", 32'(seen), 32'd1);
        @(negedge clk);
        en_filter_phase = 1'b1;
        system_filter   = 2'd3;
        input_address   = 32'h7000;
        output_address  = 32'h3000;
        @(negedge clk);
        en_filter_phase = 1'b0;
        result_block    = 0;
        wait_done(d0, 200);
        check_phase(32'h1000, 32'h2000);
        chk("ignored_filter", 32'(pix_out_filter), 32'd1);

        // Randomized phases with variable latencies and stray acks/valids
        lat_max     = 3;
        rdy_pct     = 60;
        spurious_en = 1;
        for (int p = 0; p < 6; p++) begin
            ib = $urandom & 32'hFFFFFFFC;
            ob = $urandom & 32'hFFFFFFFC;
            f  = 2'($urandom);
            d0 = done_cnt;
            start_phase(ib, ob, f, sc);
            wait_done(d0, 400);
            check_phase(ib, ob);
            chk("rnd_filter", 32'(pix_out_filter), 32'(f));
            chk("rnd_min_latency", 32'(done_cyc - sc >= 4 * NW + 1), 32'd1);
        end

        // Reset during a write aborts without a done pulse
        d0 = done_cnt;
        start_phase(32'h6000, 32'h9000, 2'd2, sc);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_write) begin
                seen = 1;
                break;
            end
        end
        chk("write_seen", 32'(seen), 32'd1);
        n_rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", 32'(done_cnt - d0), 32'd0);
        n_rst = 1'b1;
        d0 = done_cnt;
        start_phase(32'h6000, 32'h9000, 2'd2, sc);
        wait_done(d0, 400);
        check_phase(32'h6000, 32'h9000);

`ifdef MEM_TIMEOUT_EN
        // Unanswered read: watchdog flags error and still ends the phase
        begin
            int rd_cycles;
            rd_cycles   = 0;
            spurious_en = 0;
            read_block  = 1;
            start_phase(32'hA000, 32'hB000, 2'd0, sc);
            rd_cycles = 1;
            seen = 0;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (filter_phase_done) begin
                    seen = 1;
                    break;
                end
                if (mem_read) rd_cycles++;
                chk("err_before_done", 32'(phase_error), 32'd0);
            end
            chk("timeout_done", 32'(seen), 32'd1);
            chk("timeout_cycles", 32'(rd_cycles), 32'd255);
            chk("timeout_err", 32'(phase_error), 32'd1);
            chk("timeout_nowrite", 32'(wr_addr_log.size()), 32'd0);
            read_block = 0;
            d0 = done_cnt;
            start_phase(32'hA000, 32'hB000, 2'd0, sc);
            chk("err_cleared", 32'(phase_error), 32'd0);
            wait_done(d0, 400);
            check_phase(32'hA000, 32'hB000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
